// File: rtl/m_fetch_queue_if.sv
// Fetch-queue bus: redirect in, imem address/data, and the {pc, ir} head toward ID.
// Latency: none, signal bundle only.
// Backpressure: ID applies w_stall; the fetch stage never stalls the memory side.
interface m_fetch_queue_if #(
   parameter int DEPTH = 4,
   parameter int AW    = 12
);
   logic                     w_redirect;
   logic [31:0]              w_redirect_pc;
   logic [AW-1:0]            w_imem_addr;
   logic [31:0]              w_imem_data;
   logic                     w_stall;
   logic                     w_id_valid;
   logic [31:0]              w_id_pc;
   logic [31:0]              w_id_ir;
   logic                     w_halted;
   logic [$clog2(DEPTH):0]   w_occ;

   // Fetch-stage side: drives the memory address and the ID head.
   modport master (
      input  w_redirect, w_redirect_pc, w_imem_data, w_stall,
      output w_imem_addr, w_id_valid, w_id_pc, w_id_ir, w_halted, w_occ
   );

   // Surrounding pipeline side: Ex redirect, instruction memory and ID.
   modport slave (
      output w_redirect, w_redirect_pc, w_imem_data, w_stall,
      input  w_imem_addr, w_id_valid, w_id_pc, w_id_ir, w_halted, w_occ
   );
endinterface

// File: rtl/m_fetch_queue.sv
// Instruction fetch with a DEPTH-entry {pc, ir} prefetch queue; optional FQ_BYPASS_EN feeds an empty queue straight through.
// Latency: 1 cycle memory-to-ID (0 with FQ_BYPASS_EN); a redirect costs 2 bubbles (1 with FQ_BYPASS_EN).
// Backpressure: w_stall holds the head; fetch continues until the queue is full, then r_pc holds.
module m_fetch_queue #(
   parameter int DEPTH = 4,
   parameter int AW    = 12
) (
   input  logic            w_clk,
   input  logic            w_rst_n,
   input  logic            w_ce,
   m_fetch_queue_if.master fq
);
   localparam int          PW   = $clog2(DEPTH);
   localparam logic [PW:0] FULL = (PW+1)'(DEPTH);
   localparam logic [31:0] NOP  = 32'h00000013;
   localparam logic [31:0] HALT = 32'h000f0033;

   logic [31:0]   r_pc;
   logic [31:0]   r_ent_pc [DEPTH];
   logic [31:0]   r_ent_ir [DEPTH];
   logic [PW-1:0] r_head;
   logic [PW-1:0] r_tail;
   logic [PW:0]   r_count;
   logic          r_stop;

   logic          q_empty;
   logic          byp;
   logic          head_vld;
   logic [31:0]   head_pc;
   logic [31:0]   head_ir;
   logic          pop;
   logic          push;
   logic          q_wr;
   logic          q_rd;

   // Head selection and push/pop decisions; redirect wins over both.
   always_comb begin
      q_empty = (r_count == '0);
`ifdef FQ_BYPASS_EN
      byp = q_empty && !r_stop && !fq.w_redirect;
`else
      byp = 1'b0;
`endif
      head_vld = !q_empty || byp;
      head_pc  = 32'd0;
      head_ir  = NOP;
      if (byp) begin
         head_pc = r_pc;
         head_ir = fq.w_imem_data;
      end else if (!q_empty) begin
         head_pc = r_ent_pc[r_head];
         head_ir = r_ent_ir[r_head];
      end
      pop  = head_vld && !fq.w_stall && !fq.w_redirect;
      push = !r_stop && !fq.w_redirect && ((r_count != FULL) || pop);
      // A bypassed word that ID accepts this cycle never touches the storage.
      q_rd = pop && !byp;
      q_wr = push && !(byp && pop);
   end

   assign fq.w_imem_addr = r_pc[AW+1:2];
   assign fq.w_id_valid  = head_vld;
   assign fq.w_id_pc     = head_pc;
   assign fq.w_id_ir     = head_ir;
   assign fq.w_halted    = head_vld && (head_ir == HALT);
   assign fq.w_occ       = r_count;

   // Fetch PC, pointers, occupancy and halt-stop state.
   always_ff @(posedge w_clk or negedge w_rst_n) begin
      if (!w_rst_n) begin
         r_pc    <= 32'd0;
         r_head  <= '0;
         r_tail  <= '0;
         r_count <= '0;
         r_stop  <= 1'b0;
      end else if (w_ce) begin
         if (fq.w_redirect) begin
            // The halt seen so far may be wrong-path, so the stop is dropped too.
            r_pc    <= {fq.w_redirect_pc[31:2], 2'b00};
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            r_stop  <= 1'b0;
         end else begin
            if (push) begin
               r_pc <= r_pc + 32'd4;
               if (fq.w_imem_data == HALT) begin
                  r_stop <= 1'b1;
               end
            end
            if (q_wr) begin
               r_tail <= r_tail + 1'b1;
            end
            if (q_rd) begin
               r_head <= r_head + 1'b1;
            end
            case ({q_wr, q_rd})
               2'b10:   r_count <= r_count + 1'b1;
               2'b01:   r_count <= r_count - 1'b1;
               default: r_count <= r_count;
            endcase
         end
      end
   end

   // Entry storage; contents are only meaningful below r_count, so no reset.
   always_ff @(posedge w_clk) begin
      if (w_ce && q_wr) begin
         r_ent_pc[r_tail] <= r_pc;
         r_ent_ir[r_tail] <= fq.w_imem_data;
      end
   end
endmodule

// File: tb/tb_m_fetch_queue.sv
// Bench for m_fetch_queue: memory model plus a {pc, ir} scoreboard checked on every ID pop.
// Latency: checks are taken 1 time unit after each falling edge, before the next rising edge.
// Backpressure: w_stall is driven per scenario to fill and drain the queue.
module tb_m_fetch_queue;
   localparam int DEPTH = 4;
   localparam int AW    = 12;
   localparam logic [31:0] NOP  = 32'h00000013;
   localparam logic [31:0] ADDI = 32'h00108093;
   localparam logic [31:0] HALT = 32'h000f0033;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] ir;
   } ent_t;

   logic w_clk;
   logic w_rst_n;
   logic w_ce;
   logic [31:0] imem [2**AW];
   ent_t sb [$];

   int checks = 0;
   int errors = 0;

   logic        obs_valid;
   logic        obs_halted;
   logic [31:0] obs_pc;
   logic [2:0]  obs_occ;

   m_fetch_queue_if #(.DEPTH(DEPTH), .AW(AW)) bus ();

   m_fetch_queue #(.DEPTH(DEPTH), .AW(AW)) dut (
      .w_clk   (w_clk),
      .w_rst_n (w_rst_n),
      .w_ce    (w_ce),
      .fq      (bus)
   );

   assign bus.w_imem_data = imem[bus.w_imem_addr];

   initial begin
      w_clk = 1'b0;
      forever #5 w_clk = ~w_clk;
   end

   task automatic push_exp(input logic [31:0] pc);
      ent_t e;
      e.pc = pc;
      e.ir = imem[pc[AW+1:2]];
      sb.push_back(e);
   endtask

   // Observe, score any pop that the coming rising edge will perform, then move to the next falling edge.
   task automatic step(input string tag);
      ent_t e;
      #1;
      obs_valid  = bus.w_id_valid;
      obs_halted = bus.w_halted;
      obs_pc     = bus.w_id_pc;
      obs_occ    = bus.w_occ;
      if (bus.w_id_valid && !bus.w_stall && !bus.w_redirect && w_ce) begin
         checks++;
         if (sb.size() == 0) begin
            errors++;
            $display("FAIL %s unexpected_pop: got pc=%h, required no pop", tag, bus.w_id_pc);
         end else begin
            e = sb.pop_front();
            if (bus.w_id_pc !== e.pc || bus.w_id_ir !== e.ir) begin
               errors++;
               $display("FAIL %s pop: got pc=%h ir=%h, required pc=%h ir=%h",
                        tag, bus.w_id_pc, bus.w_id_ir, e.pc, e.ir);
            end
         end
      end
      @(negedge w_clk);
   endtask

   task automatic drain(input int bound, input string tag);
      for (int i = 0; i < bound && sb.size() > 0; i++) begin
         step(tag);
      end
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL %s drain: got %0d entries left, required 0", tag, sb.size());
      end
   endtask

   task automatic do_reset();
      bus.w_stall       = 1'b1;
      bus.w_redirect    = 1'b0;
      bus.w_redirect_pc = 32'd0;
      w_ce              = 1'b1;
      sb.delete();
      w_rst_n = 1'b0;
      #2;
      w_rst_n = 1'b1;
   endtask

   task automatic test_reset();
      w_rst_n = 1'b0;
      #1;
      checks += 6;
      if (bus.w_id_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b required 0", bus.w_id_valid); end
      if (bus.w_id_pc !== 32'd0) begin errors++; $display("FAIL rst_pc: got %h required 0", bus.w_id_pc); end
      if (bus.w_id_ir !== NOP) begin errors++; $display("FAIL rst_ir: got %h required %h", bus.w_id_ir, NOP); end
      if (bus.w_halted !== 1'b0) begin errors++; $display("FAIL rst_halted: got %b required 0", bus.w_halted); end
      if (bus.w_occ !== 3'd0) begin errors++; $display("FAIL rst_occ: got %0d required 0", bus.w_occ); end
      if (bus.w_imem_addr !== 12'd0) begin errors++; $display("FAIL rst_addr: got %h required 0", bus.w_imem_addr); end
      #1;
      w_rst_n = 1'b1;
      @(negedge w_clk);
   endtask

   task automatic test_stream();
      do_reset();
      for (int k = 0; k < 8; k++) push_exp(32'(4 * k));
      bus.w_stall = 1'b0;
      for (int i = 0; i < 20 && sb.size() > 0; i++) begin
         step("stream");
         checks++;
         if (obs_occ > 3'd1) begin errors++; $display("FAIL stream_occ: got %0d required <=1", obs_occ); end
         if (i > 0) begin
            checks++;
            if (obs_valid !== 1'b1) begin errors++; $display("FAIL stream_bubble: got valid=%b at cycle %0d required 1", obs_valid, i); end
         end
      end
      checks++;
      if (sb.size() != 0) begin errors++; $display("FAIL stream_drain: got %0d left required 0", sb.size()); end
      bus.w_stall = 1'b1;
   endtask

   task automatic test_stall_fill();
      do_reset();
      for (int i = 0; i < 6; i++) step("fill");
      #1;
      checks += 2;
      if (bus.w_occ !== 3'd4) begin errors++; $display("FAIL fill_occ: got %0d required 4", bus.w_occ); end
      if (bus.w_imem_addr !== 12'd4) begin errors++; $display("FAIL fill_addr: got %h required 4", bus.w_imem_addr); end
      for (int k = 0; k < 5; k++) push_exp(32'(4 * k));
      bus.w_stall = 1'b0;
      drain(12, "fill_release");
      bus.w_stall = 1'b1;
   endtask

   task automatic test_redirect();
      do_reset();
      for (int i = 0; i < 5; i++) step("redir_fill");
      #1;
      checks++;
      if (bus.w_occ !== 3'd4) begin errors++; $display("FAIL redir_full: got %0d required 4", bus.w_occ); end
      bus.w_redirect    = 1'b1;
      bus.w_redirect_pc = 32'h0000_0102;
      step("redir");
      bus.w_redirect = 1'b0;
      #1;
      checks += 2;
      if (bus.w_occ !== 3'd0) begin errors++; $display("FAIL redir_occ: got %0d required 0", bus.w_occ); end
      if (bus.w_imem_addr !== 12'h040) begin errors++; $display("FAIL redir_addr: got %h required 040", bus.w_imem_addr); end
`ifdef FQ_BYPASS_EN
      checks++;
      if (bus.w_id_valid !== 1'b1 || bus.w_id_pc !== 32'h100) begin
         errors++; $display("FAIL redir_head: got valid=%b pc=%h required 1/100", bus.w_id_valid, bus.w_id_pc);
      end
`else
      checks++;
      if (bus.w_id_valid !== 1'b0) begin errors++; $display("FAIL redir_bubble: got valid=%b required 0", bus.w_id_valid); end
`endif
      for (int k = 0; k < 4; k++) push_exp(32'h100 + 32'(4 * k));
      bus.w_stall = 1'b0;
      drain(10, "redir_drain");
      bus.w_stall = 1'b1;
   endtask

   task automatic test_halt();
      logic        seen;
      logic [31:0] hpc;
      seen = 1'b0;
      hpc  = 32'hffff_ffff;
      do_reset();
      imem[4] = HALT;
      for (int k = 0; k < 5; k++) push_exp(32'(4 * k));
      bus.w_stall = 1'b0;
      for (int i = 0; i < 12; i++) begin
         step("halt");
         if (obs_valid && obs_halted && !seen) begin
            seen = 1'b1;
            hpc  = obs_pc;
         end
      end
      #1;
      checks += 5;
      if (seen !== 1'b1) begin errors++; $display("FAIL halt_seen: got %b required 1", seen); end
      if (hpc !== 32'h10) begin errors++; $display("FAIL halt_pc: got %h required 10", hpc); end
      if (bus.w_imem_addr !== 12'd5) begin errors++; $display("FAIL halt_addr: got %h required 5", bus.w_imem_addr); end
      if (bus.w_id_valid !== 1'b0) begin errors++; $display("FAIL halt_stopped: got valid=%b required 0", bus.w_id_valid); end
      if (sb.size() != 0) begin errors++; $display("FAIL halt_drain: got %0d left required 0", sb.size()); end
      bus.w_redirect    = 1'b1;
      bus.w_redirect_pc = 32'h40;
      step("halt_redir");
      bus.w_redirect = 1'b0;
      for (int k = 0; k < 3; k++) push_exp(32'h40 + 32'(4 * k));
      drain(10, "halt_resume");
      bus.w_stall = 1'b1;
      imem[4] = ADDI;
   endtask

   task automatic test_async_reset();
      do_reset();
      for (int i = 0; i < 3; i++) step("arst_fill");
      #1;
      checks++;
      if (bus.w_occ !== 3'd3) begin errors++; $display("FAIL arst_pre_occ: got %0d required 3", bus.w_occ); end
      #1;
      w_rst_n = 1'b0;
      #1;
      checks += 5;
      if (bus.w_id_valid !== 1'b0) begin errors++; $display("FAIL arst_valid: got %b required 0", bus.w_id_valid); end
      if (bus.w_id_pc !== 32'd0) begin errors++; $display("FAIL arst_pc: got %h required 0", bus.w_id_pc); end
      if (bus.w_id_ir !== NOP) begin errors++; $display("FAIL arst_ir: got %h required %h", bus.w_id_ir, NOP); end
      if (bus.w_occ !== 3'd0) begin errors++; $display("FAIL arst_occ: got %0d required 0", bus.w_occ); end
      if (bus.w_imem_addr !== 12'd0) begin errors++; $display("FAIL arst_addr: got %h required 0", bus.w_imem_addr); end
      @(negedge w_clk);
      w_rst_n = 1'b1;
      for (int k = 0; k < 3; k++) push_exp(32'(4 * k));
      bus.w_stall = 1'b0;
      drain(8, "arst_restart");
      bus.w_stall = 1'b1;
   endtask

   task automatic test_ce();
      do_reset();
      for (int i = 0; i < 2; i++) step("ce_fill");
      w_ce              = 1'b0;
      bus.w_redirect    = 1'b1;
      bus.w_redirect_pc = 32'h200;
      for (int i = 0; i < 3; i++) begin
         step("ce_off");
         #1;
         checks += 2;
         if (bus.w_imem_addr !== 12'd2) begin errors++; $display("FAIL ce_addr: got %h required 2", bus.w_imem_addr); end
         if (bus.w_occ !== 3'd2) begin errors++; $display("FAIL ce_occ: got %0d required 2", bus.w_occ); end
      end
      w_ce = 1'b1;
      step("ce_on");
      bus.w_redirect = 1'b0;
      #1;
      checks += 2;
      if (bus.w_imem_addr !== 12'h080) begin errors++; $display("FAIL ce_redir_addr: got %h required 080", bus.w_imem_addr); end
      if (bus.w_occ !== 3'd0) begin errors++; $display("FAIL ce_redir_occ: got %0d required 0", bus.w_occ); end
      for (int k = 0; k < 3; k++) push_exp(32'h200 + 32'(4 * k));
      bus.w_stall = 1'b0;
      drain(8, "ce_resume");
      bus.w_stall = 1'b1;
   endtask

   initial begin
      for (int i = 0; i < 2**AW; i++) imem[i] = ADDI;
      w_rst_n           = 1'b0;
      w_ce              = 1'b1;
      bus.w_stall       = 1'b1;
      bus.w_redirect    = 1'b0;
      bus.w_redirect_pc = 32'd0;
      @(negedge w_clk);
      test_reset();
      test_stream();
      test_stall_fill();
      test_redirect();
      test_halt();
      test_async_reset();
      test_ce();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/m_fetch_queue.md
# m_fetch_queue

Instruction-fetch stage with a small prefetch queue. It sits between the asynchronous instruction memory and the ID stage of m_proc14, replacing the bare r_pc / IfId register pair. It owns the fetch PC and buffers fetched {pc, ir} pairs so ID stalls do not stall fetch. It flushes and refetches on any redirect from Ex (taken branch or addi-combiner skip) and stops fetching behind the halt instruction.

## Interface
- DEPTH, 4: queue entries; power of two, at least 2.
- AW, 12: instruction-memory word-address width.
- w_clk  in  1  clock; all state changes on the rising edge.
- w_rst_n  in  1  reset; **asynchronous, active-low**.
- w_ce  in  1  global clock enable; when low, no state changes.
- w_redirect  in  1  flush request from Ex (Ex_taken or combiner skip).
- w_redirect_pc  in  32  byte address to resume at; bits [1:0] ignored.
- w_imem_addr  out  AW  word address to instruction memory, equal to r_pc[AW+1:2].
- w_imem_data  in  32  instruction word; asynchronous read, valid in the same cycle.
- w_stall  in  1  ID is not accepting this cycle.
- w_id_valid  out  1  the head entry is a real instruction.
- w_id_pc  out  32  PC of the head entry; 0 when invalid.
- w_id_ir  out  32  instruction of the head entry; NOP 32'h00000013 when invalid.
- w_halted  out  1  the head entry is the halt word 32'h000f0033.
- w_occ  out  log2(DEPTH)+1  current queue occupancy.

## Operation
- State:
  - r_pc, the fetch PC.
  - Circular buffer of DEPTH {pc, ir} entries, with head pointer, tail pointer and count.
  - r_stop flag.
- Pop: occurs when w_id_valid && !w_stall. The head advances.
- Push: occurs when !r_stop, !w_redirect, and (count<DEPTH or pop). It writes {r_pc, w_imem_data} at the tail and sets r_pc <= r_pc+4.
- Halt word: if a pushed word equals 32'h000f0033, r_stop is set. While r_stop is set, no further pushes occur and r_pc holds.
- Redirect has priority over push and pop. On a redirect:
  - count, head and tail go to 0.
  - r_pc <= {w_redirect_pc[31:2],2'b00}.
  - r_stop clears, because the halt may have been wrong-path.
  - No entry is consumed that cycle, even if w_id_valid was high.
- Full queue with a pop in the same cycle: push and pop both occur; count is unchanged.
- Empty queue with no bypass: w_id_valid=0 and the NOP/0 bubble is driven.
- PC arithmetic is 32-bit modulo 2^32. w_imem_addr wraps naturally at 2^AW words.
- w_ce low: pushes, pops, redirects and r_pc updates are all suppressed. Outputs continue to reflect the current state.
- Reset: clears everything asynchronously, including a mid-flight redirect. After release, fetch restarts at PC 0.

## Timing
- Reset values:
  - r_pc=0, so w_imem_addr=0.
  - w_id_valid=0, w_id_pc=0, w_id_ir=32'h00000013.
  - w_halted=0, w_occ=0, r_stop=0.
- Normal latency: an instruction fetched at edge N is visible at the head after edge N. ID therefore sees it one cycle after its address was presented.
- Redirect latency:
  - Redirect sampled at edge N: the queue is empty after N, and w_imem_addr shows the target.
  - The target instruction is pushed at N+1 and appears at the head after N+1.
  - This gives 2 bubble cycles as seen by ID.
- Steady state with no stalls: one instruction per cycle, and w_occ stays at 1.
- Stall held for ≥DEPTH cycles: the queue fills to DEPTH. r_pc holds at the address of the next unfetched word.

## Configuration
- FQ_BYPASS_EN defined:
  - When count==0, !r_stop and !w_redirect, the outputs show {r_pc, w_imem_data} combinationally with w_id_valid=1 (and w_halted if that word is the halt word).
  - If that word is not stalled, it is consumed directly and not written into the queue; r_pc still advances.
  - If it is stalled, it is pushed normally.
  - Normal latency becomes 0 cycles and redirect bubbles become 1.
- FQ_BYPASS_EN undefined: outputs come from the queue head only. Timing is as above.

## Test plan
- Reset, then memory words 0..7 = addi x1,x1,1 (32'h00108093), no stall → w_id_pc = 0,4,8,… on consecutive cycles, w_occ ≤1, no bubbles after the first cycle.
- Hold w_stall for 6 cycles from PC 0 with DEPTH=4 → w_occ saturates at 4 and w_imem_addr holds at 4. On release, PCs 0,4,8,12,16 are delivered in order with no loss or duplication.
- Queue full and stalled, pulse w_redirect with w_redirect_pc=0x100 → w_occ=0 and w_id_valid=0 the next cycle, then w_id_pc=0x100 (0x100 directly with FQ_BYPASS_EN).
- Word at 0x10 = 32'h000f0033 → after it is pushed, w_imem_addr stays at 5. When it reaches the head, w_halted=1. A later redirect to 0x40 clears the stop and fetch resumes at 0x40.
- Deassert w_rst_n asynchronously mid-stall with w_occ=3 → all outputs return to reset values immediately, and fetch restarts from PC 0.
- w_ce=0 for 3 cycles while w_redirect=1 → no state change, and w_imem_addr is unchanged until w_ce returns high.
